matmul_dot_scheduler: RTL and testbench

- Sequences one shared dot-product datapath (multiplier bank plus product-sum adder) across every output entry of a ROWS x COLS matrix multiply.
- Issues (row, col) index pairs in row-major order and tags each in-flight issue.
- Captures the datapath sum after a fixed latency and buffers results in a credit-controlled FIFO behind a valid/ready result port.
- Sits between the matrix_multiply top-level control and the result writeback.

---
 rtl/matmul_dot_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_matmul_dot_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_dot_scheduler.sv
// matmul_dot_scheduler
//   Sequences one shared dot-product datapath over every (row, col) entry of a
//   ROWS x COLS matrix product in row-major order. Each issue carries a
//   {valid, row, col} tag through a DP_LATENCY-deep pipeline. When a tag reaches
//   the end of that pipeline, dp_sum is captured into a result FIFO behind a
//   valid/ready port. Issue is credit limited: pipeline tags plus buffered
//   results never exceed FIFO_DEPTH, so the FIFO cannot overflow.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               begin a full pass (sampled only in IDLE)
//   busy, done          pass in progress / one-cycle completion pulse
//   issue_valid/row/col operand select presented to the datapath
//   dp_sum              datapath sum, valid DP_LATENCY cycles after its issue
//   res_valid/ready     result handshake (valid = FIFO non-empty)
//   res_data/row/col    FIFO head: sum and its tags
//   stall_cycles        (only with MATMUL_SCHED_PERF_EN) RUN cycles lost to
//                       missing credit; saturating
//
// Optional feature macro: MATMUL_SCHED_PERF_EN
module matmul_dot_scheduler #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int IDX_W      = 4,
  parameter int SUM_WIDTH  = 32,
  parameter int DP_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 issue_valid,
  output logic [IDX_W-1:0]     issue_row,
  output logic [IDX_W-1:0]     issue_col,
  input  logic [SUM_WIDTH-1:0] dp_sum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SUM_WIDTH-1:0] res_data,
  output logic [IDX_W-1:0]     res_row,
  output logic [IDX_W-1:0]     res_col
`ifdef MATMUL_SCHED_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int unsigned LAT   = DP_LATENCY;
  localparam int unsigned DEPTH = FIFO_DEPTH;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INF_W = $clog2(DP_LATENCY + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;

  // Tag pipeline, stage 0 written by the issue, stage LAT-1 aligns with dp_sum.
  logic             pipe_v_q   [LAT];
  logic [IDX_W-1:0] pipe_row_q [LAT];
  logic [IDX_W-1:0] pipe_col_q [LAT];

  logic [SUM_WIDTH-1:0] mem_data_q [DEPTH];
  logic [IDX_W-1:0]     mem_row_q  [DEPTH];
  logic [IDX_W-1:0]     mem_col_q  [DEPTH];

  logic credit_ok;
  logic last_issue;
  logic push;
  logic pop;

  assign credit_ok   = (32'(inflight_q) + 32'(count_q)) < DEPTH;
  assign issue_valid = (state_q == S_RUN) && credit_ok;
  assign issue_row   = row_q;
  assign issue_col   = col_q;
  assign last_issue  = issue_valid && (row_q == IDX_W'(ROWS - 1)) &&
                       (col_q == IDX_W'(COLS - 1));

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  assign push      = pipe_v_q[LAT-1];
  assign res_valid = (count_q != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = mem_data_q[rptr_q];
  assign res_row   = mem_row_q[rptr_q];
  assign res_col   = mem_col_q[rptr_q];

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    unique case ({issue_valid, push})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push) wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    if (pop)  rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);

    if (issue_valid) begin
      if (col_q == IDX_W'(COLS - 1)) begin
        col_d = '0;
        row_d = last_issue ? '0 : row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_RUN: begin
        if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Next-state counts so done follows the final pop by exactly one cycle.
        if ((inflight_d == '0) && (count_d == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        pipe_v_q[k]   <= 1'b0;
        pipe_row_q[k] <= '0;
        pipe_col_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      pipe_v_q[0]   <= issue_valid;
      pipe_row_q[0] <= row_q;
      pipe_col_q[0] <= col_q;
      for (int unsigned k = 1; k < LAT; k++) begin
        pipe_v_q[k]   <= pipe_v_q[k-1];
        pipe_row_q[k] <= pipe_row_q[k-1];
        pipe_col_q[k] <= pipe_col_q[k-1];
      end
    end
  end

  // Result storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wptr_q] <= dp_sum;
      mem_row_q[wptr_q]  <= pipe_row_q[LAT-1];
      mem_col_q[wptr_q]  <= pipe_col_q[LAT-1];
    end
  end

`ifdef MATMUL_SCHED_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && !credit_ok && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_matmul_dot_scheduler.sv
// Directed testbench for matmul_dot_scheduler at default parameters.
// A small datapath model answers each issue with row*16+col after 2 cycles.
module tb_matmul_dot_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        issue_valid;
  logic [3:0]  issue_row;
  logic [3:0]  issue_col;
  logic [31:0] dp_sum;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_row;
  logic [3:0]  res_col;
`ifdef MATMUL_SCHED_PERF_EN
  logic [31:0] stall_cycles;
`endif

  matmul_dot_scheduler #(
    .ROWS(4), .COLS(4), .IDX_W(4), .SUM_WIDTH(32), .DP_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .issue_valid(issue_valid), .issue_row(issue_row), .issue_col(issue_col),
    .dp_sum(dp_sum), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_col(res_col)
`ifdef MATMUL_SCHED_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: two-stage operand pipeline, sum = row*16 + col.
  logic       pv [2];
  logic [3:0] pr [2];
  logic [3:0] pc [2];
  always @(posedge clk) begin
    if (rst) begin
      pv[0] <= 1'b0; pv[1] <= 1'b0;
    end else begin
      pv[0] <= issue_valid; pr[0] <= issue_row; pc[0] <= issue_col;
      pv[1] <= pv[0];       pr[1] <= pr[0];     pc[1] <= pc[0];
    end
  end
  assign dp_sum = pv[1] ? {24'd0, pr[1], pc[1]} : 32'hDEAD_BEEF;

  // Event log, sampled on the falling edge.
  int        n_iss, n_pop, n_done, max_out, first_res_cyc, done_cyc;
  logic      busy_at_done, busy_before_done, busy_prev;
  logic [7:0]  iss_tag [64];
  int          iss_cyc [64];
  logic [7:0]  pop_tag [64];
  logic [31:0] pop_data[64];
  int          pop_cyc [64];

  always @(negedge clk) begin
    if (issue_valid && n_iss < 64) begin
      iss_tag[n_iss] = {issue_row, issue_col};
      iss_cyc[n_iss] = cyc;
      n_iss++;
    end
    if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
    if (res_valid && first_res_cyc < 0) first_res_cyc = cyc;
    if (res_valid && res_ready && n_pop < 64) begin
      pop_tag[n_pop]  = {res_row, res_col};
      pop_data[n_pop] = res_data;
      pop_cyc[n_pop]  = cyc;
      n_pop++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      busy_at_done = busy;
      busy_before_done = busy_prev;
    end
    busy_prev = busy;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int run0;

  task automatic clear_log();
    n_iss = 0; n_pop = 0; n_done = 0; max_out = 0;
    first_res_cyc = -1; done_cyc = -1;
  endtask

  // Leaves the bench at posedge+1 in the first RUN cycle.
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run0 = cyc;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    n_tests++;
    if (n_done == 0) begin
      n_fail++;
      $display("FAIL %s: done timeout after %0d cycles (got 0 pulses, need 1)", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests += 5;
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
    if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b need 0", done); end
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %b need 0", issue_valid); end
    if (res_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_res_valid: got %b need 0", res_valid); end
    if ({issue_row, issue_col} !== 8'h00) begin
      n_fail++; $display("FAIL reset_indices: got %h need 00", {issue_row, issue_col});
    end
`ifdef MATMUL_SCHED_PERF_EN
    n_tests++;
    if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d need 0", stall_cycles); end
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    clear_log();
    res_ready = 1'b1;
    do_start();
    wait_done(200, "stream");
    repeat (2) @(posedge clk);
    #1;
    n_tests += 2;
    if (n_iss !== 16) begin n_fail++; $display("FAIL stream_issue_count: got %0d need 16", n_iss); end
    if (n_pop !== 16) begin n_fail++; $display("FAIL stream_pop_count: got %0d need 16", n_pop); end
    for (int i = 0; i < 16 && i < n_iss && i < n_pop; i++) begin
      n_tests += 4;
      if (iss_tag[i] !== 8'((i / 4) * 16 + i % 4)) begin
        n_fail++; $display("FAIL stream_issue_tag[%0d]: got %h need %h", i, iss_tag[i], 8'((i / 4) * 16 + i % 4));
      end
      if (iss_cyc[i] !== run0 + i) begin
        n_fail++; $display("FAIL stream_issue_cycle[%0d]: got %0d need %0d", i, iss_cyc[i], run0 + i);
      end
      if (pop_tag[i] !== 8'((i / 4) * 16 + i % 4)) begin
        n_fail++; $display("FAIL stream_pop_tag[%0d]: got %h need %h", i, pop_tag[i], 8'((i / 4) * 16 + i % 4));
      end
      if (pop_data[i] !== 32'((i / 4) * 16 + i % 4)) begin
        n_fail++; $display("FAIL stream_pop_data[%0d]: got %0d need %0d", i, pop_data[i], (i / 4) * 16 + i % 4);
      end
    end
    n_tests += 5;
    if (first_res_cyc !== run0 + 3) begin
      n_fail++; $display("FAIL stream_first_result_cycle: got %0d need %0d", first_res_cyc, run0 + 3);
    end
    if (n_pop == 16 && done_cyc !== pop_cyc[15] + 1) begin
      n_fail++; $display("FAIL stream_done_cycle: got %0d need %0d", done_cyc, pop_cyc[15] + 1);
    end else if (n_pop != 16) begin
      n_fail++; $display("FAIL stream_done_cycle: got %0d pops need 16", n_pop);
    end
    if (busy_at_done !== 1'b0)     begin n_fail++; $display("FAIL stream_busy_at_done: got %b need 0", busy_at_done); end
    if (busy_before_done !== 1'b1) begin n_fail++; $display("FAIL stream_busy_before_done: got %b need 1", busy_before_done); end
    if (n_done !== 1) begin n_fail++; $display("FAIL stream_done_count: got %0d need 1", n_done); end
  endtask

  task automatic test_backpressure();
    clear_log();
    res_ready = 1'b0;
    do_start();
    repeat (12) @(posedge clk);
    #1;
    n_tests += 3;
    if (n_iss !== 4)          begin n_fail++; $display("FAIL bp_issue_count: got %0d need 4", n_iss); end
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL bp_issue_stalled: got %b need 0", issue_valid); end
    if (busy !== 1'b1)        begin n_fail++; $display("FAIL bp_busy: got %b need 1", busy); end
    for (int k = 0; k < 3; k++) begin
      n_tests += 2;
      if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_res_valid[%0d]: got %b need 1", k, res_valid); end
      if ({res_row, res_col, res_data} !== 40'h00_0000_0000) begin
        n_fail++; $display("FAIL bp_head_stable[%0d]: got %h need 0000000000", k, {res_row, res_col, res_data});
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    n_tests++;
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_issue_on_pop: got %b need 0", issue_valid); end
    @(posedge clk); #1;
    n_tests++;
    if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume_after_pop: got %b need 1", issue_valid); end
    wait_done(200, "backpressure");
    n_tests += 2;
    if (n_iss !== 16) begin n_fail++; $display("FAIL bp_total_issues: got %0d need 16", n_iss); end
    if (n_pop !== 16) begin n_fail++; $display("FAIL bp_total_pops: got %0d need 16", n_pop); end
    for (int i = 0; i < 16 && i < n_pop; i++) begin
      n_tests++;
      if ({pop_tag[i], pop_data[i]} !== {8'((i / 4) * 16 + i % 4), 32'((i / 4) * 16 + i % 4)}) begin
        n_fail++; $display("FAIL bp_result[%0d]: got %h/%0d need %h", i, pop_tag[i], pop_data[i], 8'((i / 4) * 16 + i % 4));
      end
    end
  endtask

  task automatic test_toggle();
    int k = 0;
    clear_log();
    res_ready = 1'b1;
    do_start();
    while (n_done == 0 && k < 300) begin
      @(posedge clk); #1;
      res_ready = ~res_ready;
      k++;
    end
    res_ready = 1'b1;
    n_tests += 3;
    if (n_done !== 1) begin n_fail++; $display("FAIL toggle_done: got %0d pulses need 1", n_done); end
    if (max_out > 4)  begin n_fail++; $display("FAIL toggle_occupancy: got %0d need <= 4", max_out); end
    if (n_pop !== 16) begin n_fail++; $display("FAIL toggle_pop_count: got %0d need 16", n_pop); end
    for (int i = 0; i < 16 && i < n_pop; i++) begin
      n_tests++;
      if ({pop_tag[i], pop_data[i]} !== {8'((i / 4) * 16 + i % 4), 32'((i / 4) * 16 + i % 4)}) begin
        n_fail++; $display("FAIL toggle_result[%0d]: got %h/%0d need %h", i, pop_tag[i], pop_data[i], 8'((i / 4) * 16 + i % 4));
      end
    end
  endtask

  task automatic test_restart_ignored();
    clear_log();
    res_ready = 1'b1;
    do_start();
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200, "restart_ignored");
    repeat (6) @(posedge clk);
    #1;
    n_tests += 4;
    if (n_done !== 1)  begin n_fail++; $display("FAIL restart_done_count: got %0d need 1", n_done); end
    if (n_iss !== 16)  begin n_fail++; $display("FAIL restart_issue_count: got %0d need 16", n_iss); end
    if (n_pop !== 16)  begin n_fail++; $display("FAIL restart_pop_count: got %0d need 16", n_pop); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle_busy: got %b need 0", busy); end
    for (int i = 0; i < 16 && i < n_iss; i++) begin
      n_tests++;
      if (iss_tag[i] !== 8'((i / 4) * 16 + i % 4)) begin
        n_fail++; $display("FAIL restart_issue_tag[%0d]: got %h need %h", i, iss_tag[i], 8'((i / 4) * 16 + i % 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_log();
    res_ready = 1'b1;
    do_start();
    while (!(n_iss == 6 && issue_valid) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    n_tests++;
    if (!(n_iss == 6 && issue_valid)) begin
      n_fail++; $display("FAIL rstmid_reach_issue7: got %0d issues need 6 before current", n_iss);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_tests += 4;
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL rstmid_busy: got %b need 0", busy); end
    if (res_valid !== 1'b0)   begin n_fail++; $display("FAIL rstmid_res_valid: got %b need 0", res_valid); end
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_issue_valid: got %b need 0", issue_valid); end
    if (done !== 1'b0)        begin n_fail++; $display("FAIL rstmid_done: got %b need 0", done); end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (res_valid !== 1'b0)   begin n_fail++; $display("FAIL rstmid_no_stale: got %b need 0", res_valid); end
    clear_log();
    do_start();
    wait_done(200, "reset_mid_restart");
    n_tests += 4;
    if (n_iss !== 16) begin n_fail++; $display("FAIL rstmid_reissue_count: got %0d need 16", n_iss); end
    if (n_pop !== 16) begin n_fail++; $display("FAIL rstmid_repop_count: got %0d need 16", n_pop); end
    if (iss_tag[0] !== 8'h00 || iss_cyc[0] !== run0) begin
      n_fail++; $display("FAIL rstmid_first_issue: got %h@%0d need 00@%0d", iss_tag[0], iss_cyc[0], run0);
    end
    if ({pop_tag[0], pop_data[0]} !== 40'h00_0000_0000) begin
      n_fail++; $display("FAIL rstmid_first_result: got %h/%0d need 00/0", pop_tag[0], pop_data[0]);
    end
  endtask

`ifdef MATMUL_SCHED_PERF_EN
  task automatic test_perf();
    clear_log();
    res_ready = 1'b0;
    do_start();
    n_tests++;
    if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL perf_clear_on_start: got %0d need 0", stall_cycles); end
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cycles !== 32'd6) begin n_fail++; $display("FAIL perf_at_release: got %0d need 6", stall_cycles); end
    res_ready = 1'b1;
    wait_done(200, "perf");
    n_tests++;
    if (stall_cycles !== 32'd7) begin n_fail++; $display("FAIL perf_at_done: got %0d need 7", stall_cycles); end
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cycles !== 32'd7) begin n_fail++; $display("FAIL perf_hold_idle: got %0d need 7", stall_cycles); end
  endtask
`endif

  initial begin
    clear_log();
    busy_prev = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_restart_ignored();
    test_reset_mid();
`ifdef MATMUL_SCHED_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
